mem_responder: RTL and testbench

// Memory-side responder for the cache line refill/writeback protocol. Serves a

---
 rtl/mem_if.sv | 14 +
 rtl/mem_responder.sv | 85 ++++++++
 tb/tb_mem_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// mem_if: cache controller <-> memory responder line-transfer bus.
interface mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_read_data;
    logic        beat;
    logic        done;
    modport master (output req, we, addr, write_data, input busy, mem_addr, mem_read_data, beat, done);
    modport slave (input req, we, addr, write_data, output busy, mem_addr, mem_read_data, beat, done);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed backing store streaming whole cache lines after a fixed latency.
`ifndef CACHE_B
`define CACHE_B 4
`endif
module mem_responder #(
    parameter int OFFSET_WIDTH = `CACHE_B,
    parameter int MEM_AW = 12,
    parameter int LATENCY = 4
) (
    input logic clk,
    input logic rst_n,
    mem_if.slave bus
);
    localparam int BW = OFFSET_WIDTH - 2;
    localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
    state_t state;
    logic [31:0] base;
    logic wb;
    logic [BW-1:0] beat_cnt;
    logic [LW-1:0] lat_cnt;
    logic [31:0] mem [2**MEM_AW];
    logic [MEM_AW-1:0] idx;
    logic [31:0] line;
    assign idx = bus.mem_addr[MEM_AW+1:2];
    assign line = {bus.addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign bus.mem_read_data = bus.beat ? mem[idx] : '0;
    // A beat is committed only while req is still held, so an abort never writes its cycle.
    always_ff @(posedge clk)
        if (bus.beat && wb && bus.req) mem[idx] <= bus.write_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            base <= '0;
            wb <= 1'b0;
            beat_cnt <= '0;
            lat_cnt <= '0;
            bus.busy <= 1'b0;
            bus.beat <= 1'b0;
            bus.done <= 1'b0;
            bus.mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.req) begin
                        base <= line;
                        wb <= bus.we;
                        bus.busy <= 1'b1;
                        lat_cnt <= '0;
                        beat_cnt <= '0;
                        if (LATENCY == 0) begin
                            state <= BURST;
                            bus.beat <= 1'b1;
                            bus.mem_addr <= line;
                        end else state <= WAIT;
                    end
                end
                WAIT:
                    if (!bus.req) begin
                        state <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (lat_cnt == LW'(LATENCY - 1)) begin
                        state <= BURST;
                        bus.beat <= 1'b1;
                        bus.mem_addr <= base;
                    end else lat_cnt <= lat_cnt + LW'(1);
                BURST:
                    if (!bus.req || &beat_cnt) begin
                        state <= bus.req ? DONE : IDLE;
                        bus.done <= bus.req;
                        bus.busy <= 1'b0;
                        bus.beat <= 1'b0;
                        bus.mem_addr <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                        bus.mem_addr[OFFSET_WIDTH-1:2] <= beat_cnt + BW'(1);
                    end
                DONE: begin
                    state <= IDLE;
                    bus.done <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of refill, writeback, abort, reset and aliasing on LATENCY=4 and LATENCY=0 instances.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mem_if m4 ();
    mem_if m0 ();
    mem_responder #(.OFFSET_WIDTH(4), .MEM_AW(12), .LATENCY(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(m4.slave));
    mem_responder #(.OFFSET_WIDTH(4), .MEM_AW(12), .LATENCY(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(m0.slave));
    logic req_v [2];
    logic we_v [2];
    logic [31:0] addr_v [2];
    logic [31:0] wd_v [2];
    logic [31:0] wpat [2];
    logic by [2];
    logic bt [2];
    logic dn [2];
    logic [31:0] ma [2];
    logic [31:0] rd_o [2];
    assign m4.req = req_v[0];
    assign m4.we = we_v[0];
    assign m4.addr = addr_v[0];
    assign m4.write_data = wd_v[0];
    assign m0.req = req_v[1];
    assign m0.we = we_v[1];
    assign m0.addr = addr_v[1];
    assign m0.write_data = wd_v[1];
    assign by[0] = m4.busy;
    assign bt[0] = m4.beat;
    assign dn[0] = m4.done;
    assign ma[0] = m4.mem_addr;
    assign rd_o[0] = m4.mem_read_data;
    assign by[1] = m0.busy;
    assign bt[1] = m0.beat;
    assign dn[1] = m0.done;
    assign ma[1] = m0.mem_addr;
    assign rd_o[1] = m0.mem_read_data;
    int checks = 0;
    int errors = 0;
    int first, done_at, nb;
    logic busy1;
    logic [31:0] ad [4];
    logic [31:0] rdv [4];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // The cache side presents the word matching the beat address shown after each edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) wd_v[s] = wpat[s] + {30'd0, ma[s][3:2]};
    endtask
    task automatic reset_outputs(input string t, input int s);
        chk({t, "_busy"}, 32'(by[s]), 0);
        chk({t, "_beat"}, 32'(bt[s]), 0);
        chk({t, "_done"}, 32'(dn[s]), 0);
        chk({t, "_addr"}, ma[s], 0);
        chk({t, "_rdata"}, rd_o[s], 0);
    endtask
    task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] pat);
        wpat[s] = pat;
        wd_v[s] = pat;
        req_v[s] = 1'b1;
        we_v[s] = w;
        addr_v[s] = a;
        first = -1;
        done_at = -1;
        nb = 0;
        busy1 = 1'b0;
        for (int c = 1; c <= 30 && done_at < 0; c++) begin
            step();
            if (c == 1) begin
                busy1 = by[s];
                we_v[s] = ~w;
                addr_v[s] = 32'hDEAD_BEEF;
            end
            if (bt[s]) begin
                if (first < 0) first = c;
                if (nb < 4) begin
                    ad[nb] = ma[s];
                    rdv[nb] = rd_o[s];
                end
                nb++;
            end
            if (dn[s]) begin
                done_at = c;
                req_v[s] = 1'b0;
            end
        end
        req_v[s] = 1'b0;
        we_v[s] = 1'b0;
        step();
        chk("done_one_cycle", 32'(dn[s]), 0);
        chk("idle_after_done", 32'(by[s]), 0);
    endtask
    task automatic expect_line(input string t, input int fe, input int de, input logic [31:0] b,
                               input bit cd, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({t, "_busy"}, 32'(busy1), 1);
        chk({t, "_first"}, 32'(first), 32'(fe));
        chk({t, "_done"}, 32'(done_at), 32'(de));
        chk({t, "_beats"}, 32'(nb), 4);
        for (int i = 0; i < 4; i++) begin
            chk({t, "_addr"}, ad[i], b + 32'(4 * i));
            if (cd) chk({t, "_data"}, rdv[i], e[i]);
        end
    endtask
    initial begin
        bit stop;
        bit saw_done;
        for (int s = 0; s < 2; s++) begin
            req_v[s] = 1'b0;
            we_v[s] = 1'b0;
            addr_v[s] = '0;
            wd_v[s] = '0;
            wpat[s] = '0;
        end
        repeat (2) @(negedge clk);
        reset_outputs("rst", 0);
        reset_outputs("rst_l0", 1);
        rst_n = 1'b1;
        step();
        xfer(0, 1'b1, 32'h100, 32'hA0);
        expect_line("wb_a", 5, 9, 32'h100, 1'b0, 0, 0, 0, 0);
        xfer(0, 1'b0, 32'h104, 32'h0);
        expect_line("rf_a", 5, 9, 32'h100, 1'b1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        xfer(0, 1'b1, 32'h208, 32'hD0);
        expect_line("wb_d", 5, 9, 32'h200, 1'b0, 0, 0, 0, 0);
        xfer(0, 1'b0, 32'h200, 32'h0);
        expect_line("rf_d", 5, 9, 32'h200, 1'b1, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        xfer(0, 1'b0, 32'hFFFF_0100, 32'h0);
        expect_line("alias", 5, 9, 32'hFFFF_0100, 1'b1, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        xfer(1, 1'b1, 32'h300, 32'h50);
        expect_line("wb_l0", 1, 5, 32'h300, 1'b0, 0, 0, 0, 0);
        xfer(1, 1'b0, 32'h30C, 32'h0);
        expect_line("rf_l0", 1, 5, 32'h300, 1'b1, 32'h50, 32'h51, 32'h52, 32'h53);
        // Abort a writeback once beat 1 has been committed.
        wpat[0] = 32'hE0;
        wd_v[0] = 32'hE0;
        req_v[0] = 1'b1;
        we_v[0] = 1'b1;
        addr_v[0] = 32'h100;
        stop = 1'b0;
        for (int c = 1; c <= 20 && !stop; c++) begin
            step();
            if (bt[0] && ma[0][3:2] == 2'd2) stop = 1'b1;
        end
        chk("abort_reach_beat2", 32'(stop), 1);
        req_v[0] = 1'b0;
        we_v[0] = 1'b0;
        step();
        chk("abort_busy", 32'(by[0]), 0);
        chk("abort_beat", 32'(bt[0]), 0);
        saw_done = dn[0];
        repeat (3) begin
            step();
            saw_done |= dn[0];
        end
        chk("abort_no_done", 32'(saw_done), 0);
        xfer(0, 1'b0, 32'h100, 32'h0);
        expect_line("rf_abort", 5, 9, 32'h100, 1'b1, 32'hE0, 32'hE1, 32'hA2, 32'hA3);
        // Reset pulse while the request is still in its latency wait.
        req_v[0] = 1'b1;
        we_v[0] = 1'b0;
        addr_v[0] = 32'h104;
        step();
        step();
        chk("wait_busy", 32'(by[0]), 1);
        chk("wait_beat", 32'(bt[0]), 0);
        rst_n = 1'b0;
        #1;
        reset_outputs("midrst", 0);
        req_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        xfer(0, 1'b0, 32'h104, 32'h0);
        expect_line("rf_after_rst", 5, 9, 32'h100, 1'b1, 32'hE0, 32'hE1, 32'hA2, 32'hA3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
